// File: rtl/secure_boot_seq.sv
// Secure boot sequencer: streams boot ROM words into a SHA-256 engine and compares the digest with a golden hash.
// Optional feature macro SB_RETRY_EN: when defined, a failed attempt rehashes up to MAX_RETRY more times before lockout.
module secure_boot_seq #(
    parameter int unsigned NUM_WORDS  = 64,
    parameter logic [31:0] BASE_ADDR  = 32'h0,
    parameter int unsigned DIGEST_TMO = 1024,
    parameter int unsigned MAX_RETRY  = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    output logic         rom_cs,
    output logic         rom_rd_en,
    output logic [31:0]  rom_addr,
    input  logic [31:0]  rom_data,
    output logic         hash_init,
    output logic         hash_word_valid,
    output logic [31:0]  hash_word,
    input  logic         hash_word_ready,
    input  logic         hash_done,
    input  logic [255:0] hash_digest,
    input  logic [255:0] golden_hash,
    output logic         cpu_rst_release,
    output logic         boot_ok,
    output logic         lockout,
    output logic [1:0]   retry_cnt,
    output logic         busy
);

    localparam int unsigned IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int unsigned TMO_W = (DIGEST_TMO > 1) ? $clog2(DIGEST_TMO) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(DIGEST_TMO - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_INIT,
        S_READ,
        S_WAIT,
        S_FEED,
        S_DIGEST,
        S_CHECK,
        S_PASS,
        S_FAIL,
        S_LOCK
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] w_idx_next;
    logic [TMO_W-1:0] r_tmo;
    logic [TMO_W-1:0] w_tmo_next;
    logic [1:0]       r_retry_cnt;
    logic [1:0]       w_retry_next;
    logic [1:0]       w_retry_sat;
    logic [31:0]      r_word;
    logic [31:0]      r_rom_addr;

    assign w_retry_sat = (r_retry_cnt == 2'd3) ? 2'd3 : r_retry_cnt + 2'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_tmo       <= '0;
            r_retry_cnt <= '0;
            r_word      <= '0;
            r_rom_addr  <= '0;
        end else begin
            r_state     <= w_state_next;
            r_idx       <= w_idx_next;
            r_tmo       <= w_tmo_next;
            r_retry_cnt <= w_retry_next;
            if (r_state == S_WAIT) begin
                r_word <= rom_data;
            end
            // Address is loaded on entry to READ so it is valid during the read and held afterwards.
            if (w_state_next == S_READ) begin
                r_rom_addr <= BASE_ADDR + (32'(w_idx_next) << 2);
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        w_tmo_next   = r_tmo;
        w_retry_next = r_retry_cnt;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_INIT;
                end
            end
            S_INIT: begin
                w_idx_next   = '0;
                w_state_next = S_READ;
            end
            S_READ: begin
                w_state_next = S_WAIT;
            end
            S_WAIT: begin
                w_state_next = S_FEED;
            end
            S_FEED: begin
                if (hash_word_ready) begin
                    if (r_idx == LAST_IDX) begin
                        w_tmo_next   = '0;
                        w_state_next = S_DIGEST;
                    end else begin
                        w_idx_next   = r_idx + IDX_W'(1);
                        w_state_next = S_READ;
                    end
                end
            end
            S_DIGEST: begin
                if (hash_done) begin
                    w_state_next = S_CHECK;
                end else if (r_tmo == TMO_LAST) begin
                    w_state_next = S_FAIL;
                end else begin
                    w_tmo_next = r_tmo + TMO_W'(1);
                end
            end
            S_CHECK: begin
                w_state_next = (hash_digest == golden_hash) ? S_PASS : S_FAIL;
            end
            S_FAIL: begin
`ifdef SB_RETRY_EN
                w_retry_next = w_retry_sat;
                w_state_next = (32'(r_retry_cnt) < MAX_RETRY) ? S_INIT : S_LOCK;
`else
                w_retry_next = 2'd1;
                w_state_next = S_LOCK;
`endif
            end
            S_PASS: begin
                w_state_next = S_PASS;
            end
            S_LOCK: begin
                w_state_next = S_LOCK;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign rom_cs          = (r_state == S_READ);
    assign rom_rd_en       = (r_state == S_READ);
    assign rom_addr        = r_rom_addr;
    assign hash_init       = (r_state == S_INIT);
    assign hash_word_valid = (r_state == S_FEED);
    assign hash_word       = r_word;
    assign cpu_rst_release = (r_state == S_PASS);
    assign boot_ok         = (r_state == S_PASS);
    assign lockout         = (r_state == S_LOCK);
    assign retry_cnt       = r_retry_cnt;
    assign busy            = (r_state != S_IDLE) && (r_state != S_PASS) && (r_state != S_LOCK);

endmodule

// File: tb/tb_secure_boot_seq.sv
// Self-checking bench for secure_boot_seq: behavioural ROM and hash-engine models with
// random ROM contents and digests, checked against the expected word/address stream and outcome.
module tb_secure_boot_seq;

    localparam int unsigned NW   = 4;
    localparam logic [31:0] BASE = 32'h0000_2000;
    localparam int unsigned TMO  = 16;
    localparam int unsigned MR   = 2;
`ifdef SB_RETRY_EN
    localparam int ATTEMPTS = MR + 1;
`else
    localparam int ATTEMPTS = 1;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         rom_cs;
    logic         rom_rd_en;
    logic [31:0]  rom_addr;
    logic [31:0]  rom_data = '0;
    logic         hash_init;
    logic         hash_word_valid;
    logic [31:0]  hash_word;
    logic         hash_word_ready = 1'b0;
    logic         hash_done = 1'b0;
    logic [255:0] hash_digest = '0;
    logic [255:0] golden_hash = '0;
    logic         cpu_rst_release;
    logic         boot_ok;
    logic         lockout;
    logic [1:0]   retry_cnt;
    logic         busy;

    secure_boot_seq #(
        .NUM_WORDS (NW),
        .BASE_ADDR (BASE),
        .DIGEST_TMO(TMO),
        .MAX_RETRY (MR)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .rom_cs         (rom_cs),
        .rom_rd_en      (rom_rd_en),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .hash_init      (hash_init),
        .hash_word_valid(hash_word_valid),
        .hash_word      (hash_word),
        .hash_word_ready(hash_word_ready),
        .hash_done      (hash_done),
        .hash_digest    (hash_digest),
        .golden_hash    (golden_hash),
        .cpu_rst_release(cpu_rst_release),
        .boot_ok        (boot_ok),
        .lockout        (lockout),
        .retry_cnt      (retry_cnt),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    logic [31:0]  rom_mem [NW];
    logic [31:0]  q_addr [$];
    logic [31:0]  q_words [$];
    int           q_hs_cyc [$];
    int           n_init = 0;
    int           cyc = 0;
    int           n_checks = 0;
    int           n_errors = 0;
    int unsigned  rom_wi;
    logic [255:0] bad_hash;

    always @(posedge clk) cyc <= cyc + 1;

    // ROM model: one-cycle read latency, word index derived from the byte address.
    always @(posedge clk) begin
        if (rom_cs && rom_rd_en) begin
            rom_wi = (rom_addr - BASE) >> 2;
            rom_data <= (rom_wi < NW) ? rom_mem[rom_wi] : 32'hDEAD_BEEF;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (rom_cs && rom_rd_en) q_addr.push_back(rom_addr);
            if (hash_word_valid && hash_word_ready) begin
                q_words.push_back(hash_word);
                q_hs_cyc.push_back(cyc);
            end
            if (hash_init) n_init++;
        end
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic randomize_data();
        for (int i = 0; i < int'(NW); i++) rom_mem[i] = $urandom;
        golden_hash = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        bad_hash = golden_hash ^ {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        bad_hash[17] = ~golden_hash[17];
    endtask

    task automatic do_reset();
        rst = 1'b1;
        start = 1'b0;
        hash_word_ready = 1'b0;
        hash_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        q_addr.delete();
        q_words.delete();
        q_hs_cyc.delete();
        n_init = 0;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_words(input int n, input string tag);
        int k = 0;
        while (q_words.size() < n && k < 1000) begin
            @(negedge clk);
            k++;
        end
        chk(tag, q_words.size() >= n, 1);
    endtask

    task automatic wait_end(input string tag);
        int k = 0;
        while (!(boot_ok || lockout) && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk(tag, boot_ok || lockout, 1);
    endtask

    task automatic feed_done(input int n_words_total);
        wait_words(n_words_total, "wait_words_done");
        repeat (2) @(posedge clk);
        #1 hash_done = 1'b1;
        repeat (2) @(posedge clk);
        #1 hash_done = 1'b0;
    endtask

    task automatic check_stream(input string tag, input int attempts);
        chk({tag, "_naddr"}, q_addr.size(), NW * attempts);
        chk({tag, "_nword"}, q_words.size(), NW * attempts);
        for (int i = 0; i < q_addr.size() && i < int'(NW) * attempts; i++)
            chk({tag, "_addr"}, q_addr[i], BASE + 32'(4 * (i % NW)));
        for (int i = 0; i < q_words.size() && i < int'(NW) * attempts; i++)
            chk({tag, "_word"}, q_words[i], rom_mem[i % NW]);
    endtask

    function automatic logic [255:0] all_outs();
        return {rom_cs, rom_rd_en, rom_addr, hash_init, hash_word_valid, hash_word,
                cpu_rst_release, boot_ok, lockout, retry_cnt, busy};
    endfunction

    initial begin
        logic [31:0] held;
        int          n_rd;
        int          k;
        int          hit_cyc;

        // Reset state
        randomize_data();
        do_reset();
        @(negedge clk);
        chk("reset_outs", all_outs(), '0);

        // Golden match, ready always high; a start while busy must be ignored
        randomize_data();
        hash_digest = golden_hash;
        hash_word_ready = 1'b1;
        pulse_start();
        wait_words(2, "gold_w2");
        pulse_start();
        feed_done(NW);
        wait_end("gold_end");
        chk("gold_boot_ok", boot_ok, 1);
        chk("gold_rst_rel", cpu_rst_release, 1);
        chk("gold_lockout", lockout, 0);
        chk("gold_busy", busy, 0);
        chk("gold_retry", retry_cnt, 0);
        chk("gold_ninit", n_init, 1);
        check_stream("gold", 1);
        for (int i = 1; i < q_hs_cyc.size(); i++)
            chk("gold_rate", q_hs_cyc[i] - q_hs_cyc[i-1], 3);
        pulse_start();
        repeat (4) @(negedge clk);
        chk("pass_sticky", {boot_ok, cpu_rst_release, busy}, 3'b110);
        chk("pass_no_rerun", n_init, 1);

        // Backpressure on word 2, with an early hash_done that must be ignored
        randomize_data();
        do_reset();
        hash_digest = golden_hash;
        hash_word_ready = 1'b1;
        pulse_start();
        wait_words(2, "bp_w2");
        @(posedge clk);
        #1 hash_word_ready = 1'b0;
        k = 0;
        while (!hash_word_valid && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("bp_valid_seen", hash_word_valid, 1);
        held = hash_word;
        n_rd = q_addr.size();
        chk("bp_word2", held, rom_mem[2]);
        hash_done = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("bp_hold_valid", hash_word_valid, 1);
            chk("bp_hold_word", hash_word, held);
        end
        chk("bp_no_extra_rd", q_addr.size(), n_rd);
        chk("bp_no_extra_hs", q_words.size(), 2);
        @(posedge clk);
        #1 hash_word_ready = 1'b1;
        wait_end("bp_end");
        hash_done = 1'b0;
        chk("bp_boot_ok", boot_ok, 1);
        check_stream("bp", 1);

        // Persistent digest mismatch
        randomize_data();
        do_reset();
        hash_digest = bad_hash;
        hash_word_ready = 1'b1;
        pulse_start();
        for (int a = 0; a < ATTEMPTS; a++) feed_done(NW * (a + 1));
        wait_end("mm_end");
        chk("mm_lockout", lockout, 1);
        chk("mm_boot_ok", boot_ok, 0);
        chk("mm_rst_rel", cpu_rst_release, 0);
        chk("mm_retry", retry_cnt, ATTEMPTS);
        chk("mm_ninit", n_init, ATTEMPTS);
        chk("mm_busy", busy, 0);
        check_stream("mm", ATTEMPTS);
        pulse_start();
        repeat (4) @(negedge clk);
        chk("lock_sticky", {lockout, cpu_rst_release, busy}, 3'b100);
        chk("lock_no_rerun", n_init, ATTEMPTS);

        // Digest timeout: hash_done never arrives
        randomize_data();
        do_reset();
        hash_digest = golden_hash;
        hash_word_ready = 1'b1;
        pulse_start();
        wait_words(NW, "tmo_words");
        k = 0;
        hit_cyc = -1;
        while (k < 100) begin
            @(negedge clk);
            k++;
            if (lockout || hash_init) begin
                hit_cyc = cyc;
                break;
            end
        end
        // Handshake visible at cycle c; DIGEST from c+1; FAIL at c+1+TMO; follow-up state one cycle later.
        chk("tmo_latency", hit_cyc - q_hs_cyc[NW-1], 1 + TMO + 1);
        wait_end("tmo_end");
        chk("tmo_lockout", lockout, 1);
        chk("tmo_retry", retry_cnt, ATTEMPTS);
        chk("tmo_boot_ok", boot_ok, 0);

        // Reset in the middle of FEED, then a clean rerun
        randomize_data();
        do_reset();
        hash_digest = golden_hash;
        hash_word_ready = 1'b0;
        pulse_start();
        k = 0;
        while (!hash_word_valid && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("mid_valid_seen", hash_word_valid, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_outs", all_outs(), '0);
        @(negedge clk);
        chk("mid_rst_outs2", all_outs(), '0);
        q_addr.delete();
        q_words.delete();
        q_hs_cyc.delete();
        n_init = 0;
        @(posedge clk);
        #1 rst = 1'b0;
        hash_word_ready = 1'b1;
        pulse_start();
        feed_done(NW);
        wait_end("mid_end");
        chk("mid_ninit", n_init, 1);
        chk("mid_boot_ok", boot_ok, 1);
        check_stream("mid", 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

endmodule
